// File: rtl/subleq_pkg.sv
// Shared SUBLEQ definitions: the memory responder state, default widths, and
// the CPU control state encodings that benches use as a reference.
package subleq_pkg;

   localparam int SUBLEQ_DATA_W = 16;
   localparam int SUBLEQ_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_RESP = 2'd1,
      WR_RESP = 2'd2
   } resp_state_e;

   // CPU control state encodings (0..12), kept here so every block agrees
   typedef enum logic [3:0] {
      CPU_RESET     = 4'd0,
      CPU_FETCH_A   = 4'd1,
      CPU_LOAD_A    = 4'd2,
      CPU_FETCH_B   = 4'd3,
      CPU_LOAD_B    = 4'd4,
      CPU_FETCH_C   = 4'd5,
      CPU_LOAD_C    = 4'd6,
      CPU_FETCH_MA  = 4'd7,
      CPU_LOAD_MA   = 4'd8,
      CPU_FETCH_MB  = 4'd9,
      CPU_LOAD_MB   = 4'd10,
      CPU_WRITEBACK = 4'd11,
      CPU_HALT      = 4'd12
   } cpu_state_e;

endpackage

// File: rtl/subleq_ram.sv
// Single-port synchronous RAM: one write port, registered read, shared address.
module subleq_ram #(
   parameter int W     = 16,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] a,
   input  logic [W-1:0]  d,
   output logic [W-1:0]  q
);

   logic [W-1:0] mem [DEPTH];

   // write on the edge; read data registered for the following cycle
   always_ff @(posedge clk) begin
      if (we) mem[a] <= d;
      if (re) q <= mem[a];
   end

endmodule

// File: rtl/subleq_mem_resp.sv
// SUBLEQ memory responder: CPU read/write strobes and host program-load port
// muxed onto one synchronous RAM. Read data appears the cycle after the strobe.
// Optional feature: define SUBLEQ_MEM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on read through par_err.
module subleq_mem_resp
   import subleq_pkg::*;
#(
   parameter int DATA_W = SUBLEQ_DATA_W,
   parameter int ADDR_W = SUBLEQ_ADDR_W,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              prog_mode,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              wr_done,
   output logic              addr_err,
   output logic              cmd_err
`ifdef SUBLEQ_MEM_PARITY_EN
   ,output logic             par_err
`endif
);

`ifdef SUBLEQ_MEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   resp_state_e       state, state_nxt;
   logic              cpu_rd, cpu_wr, cpu_in_rng, load_in_rng, host_wr;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_a;
   logic [DATA_W-1:0] ram_wd, rd_fresh, rdata_hold;
   logic [RAM_W-1:0]  ram_d, ram_q;
   logic              rd_oor_q, addr_err_nxt, cmd_err_nxt;

   // request decode and CPU/host steering onto the single RAM port
   always_comb begin
      cpu_in_rng   = {1'b0, addr} < DEPTH_C;
      load_in_rng  = {1'b0, load_addr} < DEPTH_C;
      cpu_rd       = mem_read & ~mem_write & ~prog_mode;
      cpu_wr       = mem_write & ~prog_mode;
      host_wr      = load_en & prog_mode;
      ram_a        = prog_mode ? load_addr : addr;
      ram_wd       = prog_mode ? load_data : wdata;
      ram_we       = prog_mode ? (host_wr & load_in_rng) : (cpu_wr & cpu_in_rng);
      ram_re       = cpu_rd & cpu_in_rng;
      addr_err_nxt = ((cpu_rd | cpu_wr) & ~cpu_in_rng) | (host_wr & ~load_in_rng);
      cmd_err_nxt  = (mem_read & mem_write) | (prog_mode & (mem_read | mem_write));
`ifdef SUBLEQ_MEM_PARITY_EN
      ram_d        = {^ram_wd, ram_wd};
`else
      ram_d        = ram_wd;
`endif
   end

   subleq_ram #(.W(RAM_W), .DEPTH(DEPTH), .AW(ADDR_W)) u_ram (
      .clk (clk),
      .we  (ram_we),
      .re  (ram_re),
      .a   (ram_a),
      .d   (ram_d),
      .q   (ram_q)
   );

   // responder state register; reset drops any pending response pulse
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state follows the strobe accepted this cycle; pulses decode from state
   always_comb begin
      state_nxt   = IDLE;
      rdata_valid = 1'b0;
      wr_done     = 1'b0;
      if (cpu_wr)      state_nxt = WR_RESP;
      else if (cpu_rd) state_nxt = RD_RESP;
      case (state)
         RD_RESP: rdata_valid = 1'b1;
         WR_RESP: wr_done     = 1'b1;
         default: ;
      endcase
   end

   // error pulses and out-of-range read marker, one cycle after the request
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err <= 1'b0;
         cmd_err  <= 1'b0;
         rd_oor_q <= 1'b0;
      end else begin
         addr_err <= addr_err_nxt;
         cmd_err  <= cmd_err_nxt;
         rd_oor_q <= cpu_rd & ~cpu_in_rng;
      end
   end

   assign rd_fresh = rd_oor_q ? '0 : ram_q[DATA_W-1:0];

   // hold the last returned word until the next accepted read
   always_ff @(posedge clk) begin
      if (rst)                  rdata_hold <= '0;
      else if (state == RD_RESP) rdata_hold <= rd_fresh;
   end

   assign rdata = (state == RD_RESP) ? rd_fresh : rdata_hold;

`ifdef SUBLEQ_MEM_PARITY_EN
   // stored word plus parity bit must XOR to zero for even parity
   assign par_err = (state == RD_RESP) & ~rd_oor_q & (^ram_q);
`endif

endmodule

// File: tb/tb_subleq_mem_resp.sv
// Directed bench for subleq_mem_resp (DEPTH=200 so out-of-range is reachable).
module tb_subleq_mem_resp;

   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst, mem_read, mem_write, prog_mode, load_en;
   logic [AW-1:0] addr, load_addr;
   logic [DW-1:0] wdata, load_data, rdata;
   logic          rdata_valid, wr_done, addr_err, cmd_err;
`ifdef SUBLEQ_MEM_PARITY_EN
   logic          par_err;
`endif
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   subleq_mem_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) u_dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .prog_mode(prog_mode), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .rdata(rdata),
      .rdata_valid(rdata_valid), .wr_done(wr_done), .addr_err(addr_err),
      .cmd_err(cmd_err)
`ifdef SUBLEQ_MEM_PARITY_EN
      , .par_err(par_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one edge and settle past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      mem_read = 0; mem_write = 0; load_en = 0;
   endtask

   task automatic host_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      prog_mode = 1; load_en = 1; load_addr = a; load_data = d;
      step();
      load_en = 0;
   endtask

   task automatic cpu_read(input logic [AW-1:0] a);
      mem_read = 1; mem_write = 0; addr = a;
      step();
   endtask

`ifdef SUBLEQ_MEM_PARITY_EN
   task automatic flip_parity(input int a);
      u_dut.u_ram.mem[a][DW] = ~u_dut.u_ram.mem[a][DW];
   endtask
`endif

   initial begin
      rst = 1; prog_mode = 0; addr = 0; wdata = 0; load_addr = 0; load_data = 0;
      idle_in();
      step(); step();
      chk("rst_rdata", rdata, 0);
      chk("rst_valid", rdata_valid, 0);
      chk("rst_wr_done", wr_done, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_cmd_err", cmd_err, 0);
      rst = 0;

      // host load then read
      host_load(0, 16'h0003);
      host_load(1, 16'h0007);
      prog_mode = 0;
      cpu_read(1);
      chk("hl_rdata", rdata, 16'h0007);
      chk("hl_valid", rdata_valid, 1);
      idle_in(); step();
      chk("hl_valid_drop", rdata_valid, 0);
      chk("hl_rdata_hold", rdata, 16'h0007);

      // write then read-after-write
      mem_write = 1; addr = 8'h10; wdata = 16'hFFFE;
      step();
      chk("wr_done", wr_done, 1);
      chk("wr_no_valid", rdata_valid, 0);
      cpu_read(8'h10);
      chk("raw_wr_done_drop", wr_done, 0);
      chk("raw_rdata", rdata, 16'hFFFE);
      chk("raw_valid", rdata_valid, 1);
      idle_in();

      // back-to-back reads
      host_load(0, 16'h000A);
      host_load(1, 16'h000B);
      host_load(2, 16'h000C);
      prog_mode = 0;
      cpu_read(0);
      chk("b2b0", {rdata_valid, rdata}, {1'b1, 16'h000A});
      cpu_read(1);
      chk("b2b1", {rdata_valid, rdata}, {1'b1, 16'h000B});
      cpu_read(2);
      chk("b2b2", {rdata_valid, rdata}, {1'b1, 16'h000C});
      idle_in(); step();
      chk("b2b_end", rdata_valid, 0);

      // host load out of range is dropped with addr_err
      host_load(210, 16'hBEEF);
      chk("host_oor_addr_err", addr_err, 1);
      chk("host_oor_cmd_err", cmd_err, 0);
      prog_mode = 0; step();
      chk("host_oor_clear", addr_err, 0);

      // read+write together: write wins
      mem_read = 1; mem_write = 1; addr = 5; wdata = 16'h1234;
      step();
      chk("rw_cmd_err", cmd_err, 1);
      chk("rw_wr_done", wr_done, 1);
      chk("rw_no_valid", rdata_valid, 0);
      chk("rw_addr_err", addr_err, 0);
      cpu_read(5);
      chk("rw_mem5", rdata, 16'h1234);
      chk("rw_cmd_clear", cmd_err, 0);

      // out-of-range read and write
      cpu_read(250);
      chk("oor_rd", {rdata_valid, addr_err, rdata}, {1'b1, 1'b1, 16'h0000});
      mem_read = 0; mem_write = 1; addr = 220; wdata = 16'h7777;
      step();
      chk("oor_wr", {wr_done, addr_err}, 2'b11);
      idle_in();

      // prog_mode lockout
      prog_mode = 1; mem_write = 1; addr = 2; wdata = 16'hDEAD;
      step();
      chk("lock_cmd_err", cmd_err, 1);
      chk("lock_no_wr_done", wr_done, 0);
      idle_in(); prog_mode = 0;
      cpu_read(2);
      chk("lock_mem2", rdata, 16'h000C);
      idle_in();

      // load_en ignored outside prog_mode
      load_en = 1; load_addr = 2; load_data = 16'h5555;
      step();
      chk("silent_load_err", {addr_err, cmd_err}, 2'b00);
      load_en = 0;
      cpu_read(2);
      chk("silent_load_mem2", rdata, 16'h000C);

      // reset the cycle after a read strobe
      cpu_read(1);
      chk("prerst_rdata", rdata, 16'h000B);
      idle_in(); rst = 1;
      step();
      chk("rst_rd_valid", rdata_valid, 0);
      chk("rst_rd_rdata", rdata, 0);
      rst = 0;
      cpu_read(8'h10);
      chk("rst_keeps_mem", rdata, 16'hFFFE);
      idle_in();

`ifdef SUBLEQ_MEM_PARITY_EN
      mem_write = 1; addr = 8'h20; wdata = 16'h0001;
      step();
      cpu_read(8'h20);
      chk("par_clean", {rdata_valid, par_err}, 2'b10);
      idle_in(); step();
      flip_parity(8'h20);
      cpu_read(8'h20);
      chk("par_err", {rdata_valid, par_err}, 2'b11);
      idle_in();
`endif

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
